// File: rtl/inst_rom_responder.sv
// inst_rom_responder: wait-stated instruction memory answering the core's fetch stage, with a boot-load port.
// Define INST_ROM_BYTESWAP_EN to byte-reverse each word on read (little-endian image, big-endian core).
module inst_rom_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     inst,
    output logic                  inst_valid,
    output logic                  stall_req,
    output logic                  err,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   inst_q, inst_d, raw_word, rd_word;
    logic                valid_q, valid_d, err_q, err_d, bad;
    logic [DATA_W-1:0]   mem [2**DEPTH_LOG2];

    // Non-blocking write makes a same-edge read see the old word.
    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr] <= load_data;
    end

    assign raw_word = mem[addr_q[DEPTH_LOG2+1:2]];
`ifdef INST_ROM_BYTESWAP_EN
    assign rd_word = {<<8{raw_word}};
`else
    assign rd_word = raw_word;
`endif
    assign bad = (|addr_q[1:0]) || (|addr_q[ADDR_W-1:DEPTH_LOG2+2]);

    assign stall_req  = ce && !(state_q == S_RESP && addr == addr_q);
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (ce) begin
                    addr_d  = addr;
                    cnt_d   = RELOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ce) begin
                    state_d = S_IDLE;
                end else if (addr != addr_q) begin
                    addr_d = addr;
                    cnt_d  = RELOAD;
                end else if (cnt_q == 4'd0) begin
                    inst_d  = bad ? '0 : rd_word;
                    err_d   = bad;
                    valid_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (!ce || addr != addr_q) begin
                    inst_d  = '0;
                    valid_d = 1'b0;
                    state_d = ce ? S_WAIT : S_IDLE;
                    addr_d  = ce ? addr : addr_q;
                    cnt_d   = ce ? RELOAD : cnt_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_inst_rom_responder.sv
// tb_inst_rom_responder: directed self-checking bench for inst_rom_responder (default parameters, WAIT_CYCLES=1).
module tb_inst_rom_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall_req;
    logic        err;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    int          checks = 0;
    int          errors = 0;

    inst_rom_responder dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
        .inst_valid(inst_valid), .stall_req(stall_req), .err(err),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents a fetch and counts the cycles stall_req stays high (bounded).
    task automatic do_fetch(input logic [31:0] a, output int n);
        ce   = 1'b1;
        addr = a;
        #1;
        n = 0;
        while (stall_req && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b0; addr = '0; load_we = 1'b1;
        load_addr = 10'd0; load_data = 32'h3401_1100;
        tick();
        load_addr = 10'd1; load_data = 32'h3402_0020;
        tick();
        load_we = 1'b0;
        tick();
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 00000000", inst); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b1;
    endtask

    task automatic test_first_fetch();
        int n;
        do_fetch(32'h0, n);
        checks++; if (n != 3) begin errors++; $display("FAIL first_stall got %0d want 3", n); end
        checks++; if (inst !== 32'h3401_1100) begin errors++; $display("FAIL first_inst got %h want 34011100", inst); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", inst_valid); end
    endtask

    task automatic test_sequential();
        int n;
        addr = 32'h4;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL seq_stall_rise got %b want 1", stall_req); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_wait got %b want 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL seq_inst_wait got %h want 00000000", inst); end
        n = 1;
        while (stall_req && n < 20) begin
            n++;
            tick();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL seq_stall got %0d want 3", n); end
        checks++; if (inst !== 32'h3402_0020) begin errors++; $display("FAIL seq_inst got %h want 34020020", inst); end
    endtask

    task automatic test_mid_wait();
        int n;
        addr = 32'h0;
        tick();
        do_fetch(32'h4, n);
        checks++; if (n != 3) begin errors++; $display("FAIL midwait_stall got %0d want 3", n); end
        checks++; if (inst !== 32'h3402_0020) begin errors++; $display("FAIL midwait_inst got %h want 34020020", inst); end
    endtask

    task automatic test_errors();
        int n;
        do_fetch(32'h2, n);
        checks++; if (n != 3) begin errors++; $display("FAIL misalign_stall got %0d want 3", n); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL misalign_inst got %h want 00000000", inst); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_err got %b want 1", err); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL misalign_valid got %b want 1", inst_valid); end
        do_fetch(32'h0000_1000, n);
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL range_inst got %h want 00000000", inst); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_err got %b want 1", err); end
        do_fetch(32'h0, n);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
        checks++; if (inst !== 32'h3401_1100) begin errors++; $display("FAIL err_clear_inst got %h want 34011100", inst); end
    endtask

    task automatic test_ce_drop();
        int n;
        int pulses;
        ce = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL ce0_stall got %b want 0", stall_req); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ce0_valid got %b want 0", inst_valid); end
        ce = 1'b1; addr = 32'h4;
        tick();
        ce = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (inst_valid) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL wait_drop_pulse got %0d want 0", pulses); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL wait_drop_stall got %b want 0", stall_req); end
        do_fetch(32'h4, n);
        checks++; if (n != 3) begin errors++; $display("FAIL after_drop_stall got %0d want 3", n); end
        checks++; if (inst !== 32'h3402_0020) begin errors++; $display("FAIL after_drop_inst got %h want 34020020", inst); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_fetch(32'h2, n);
        addr = 32'h0;
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_hold_wait got %b want 1", err); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL leave_resp_valid got %b want 0", inst_valid); end
        rst = 1'b0;
        tick();
        checks++; if (inst !== 32'h0 || inst_valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rst_mid got inst=%h valid=%b err=%b want 0/0/0", inst, inst_valid, err);
        end
        rst = 1'b1; ce = 1'b0;
        tick();
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_noresp got %b want 0", inst_valid); end
        do_fetch(32'h0, n);
        checks++; if (n != 3) begin errors++; $display("FAIL rst_mid_refetch got %0d want 3", n); end
    endtask

    task automatic test_collision();
        int n;
        logic [31:0] exp_new;
`ifdef INST_ROM_BYTESWAP_EN
        exp_new = 32'hDDCC_BBAA;
`else
        exp_new = 32'hAABB_CCDD;
`endif
        ce = 1'b0;
        tick();
        ce = 1'b1; addr = 32'h0;
        tick();
        tick();
        load_we = 1'b1; load_addr = 10'd0; load_data = 32'hAABB_CCDD;
        tick();
        load_we = 1'b0;
        checks++; if (inst !== 32'h3401_1100) begin errors++; $display("FAIL collide_old got %h want 34011100", inst); end
        ce = 1'b0;
        tick();
        do_fetch(32'h0, n);
        checks++; if (inst !== exp_new) begin errors++; $display("FAIL collide_new got %h want %h", inst, exp_new); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_mid_wait();
        test_errors();
        test_ce_drop();
        test_reset_mid();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
